// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: sequencer for the VGA obstacle-crossing game.
// Owns the game FSM, obstacle-shift and player-move tick generation,
// lives / score / level bookkeeping, and the strobes that drive the
// row and player registers.
//
// Ports:
//   board_clk            system clock
//   reset                asynchronous, active-high
//   start                start switch (level)
//   btn_u/d/l/r          debounced buttons (level)
//   hit, goal            collision / ending-row flags from playfield logic
//   state[2:0]           IDLE=0 PLAY=1 HIT=2 WIN=3 OVER=4
//   obst_en              1-cycle pulse: shift obstacle rows
//   move_en, move_dir    1-cycle pulse + direction (0=down 1=up 2=right 3=left)
//   load_rows            1-cycle pulse: reload obstacle patterns
//   load_player          1-cycle pulse: respawn player
//   lives[1:0], score[3:0], level[1:0], won
module game_seq_ctrl #(
  parameter int OBST_DIV   = 8388608,
  parameter int PLAYER_DIV = 4194304,
  parameter int HOLD_CYC   = 25000000,
  parameter int LIVES      = 3,
  parameter int SCORE_MAX  = 10
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       hit,
  input  logic       goal,
  output logic [2:0] state,
  output logic       obst_en,
  output logic       move_en,
  output logic [1:0] move_dir,
  output logic       load_rows,
  output logic       load_player,
  output logic [1:0] lives,
  output logic [3:0] score,
  output logic [1:0] level,
  output logic       won
);

  localparam int OW = (OBST_DIV   > 2) ? $clog2(OBST_DIV)   : 1;
  localparam int PW = (PLAYER_DIV > 2) ? $clog2(PLAYER_DIV) : 1;
  localparam int HW = (HOLD_CYC   > 2) ? $clog2(HOLD_CYC)   : 1;

  localparam logic [PW-1:0] PLY_LIM  = PW'(PLAYER_DIV - 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_CYC - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
  localparam logic [3:0]    SCORE_TOP  = 4'(SCORE_MAX);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    WIN  = 3'd3,
    OVER = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            start_q;
  logic [OW-1:0]   obst_cnt_q, obst_cnt_d;
  logic [PW-1:0]   ply_cnt_q, ply_cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            obst_en_q, obst_en_d;
  logic            move_en_q, move_en_d;
  logic [1:0]      move_dir_q, move_dir_d;
  logic            load_rows_q, load_rows_d;
  logic            load_player_q, load_player_d;
  logic [1:0]      lives_q, lives_d;
  logic [3:0]      score_q, score_d;
  logic [1:0]      level_q, level_d;
  logic            won_q, won_d;

  logic            start_rise;
  logic [OW-1:0]   obst_lim;
  logic            obst_wrap;
  logic            ply_wrap;
  logic            btn_one;
  logic [1:0]      btn_dir;

  assign start_rise = start & ~start_q;
  // Each level halves the obstacle period.
  assign obst_lim   = OW'((OBST_DIV >> level_q) - 1);
  assign obst_wrap  = (obst_cnt_q == obst_lim);
  assign ply_wrap   = (ply_cnt_q == PLY_LIM);

  always_comb begin
    btn_one = 1'b1;
    btn_dir = 2'd0;
    unique case ({btn_u, btn_d, btn_l, btn_r})
      4'b1000: btn_dir = 2'd1;
      4'b0100: btn_dir = 2'd0;
      4'b0010: btn_dir = 2'd3;
      4'b0001: btn_dir = 2'd2;
      default: btn_one = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    obst_cnt_d    = '0;
    ply_cnt_d     = '0;
    hold_d        = '0;
    obst_en_d     = 1'b0;
    move_en_d     = 1'b0;
    move_dir_d    = move_dir_q;
    load_rows_d   = 1'b0;
    load_player_d = 1'b0;
    lives_d       = lives_q;
    score_d       = score_q;
    level_d       = level_q;
    won_d         = won_q;

    unique case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          lives_d       = LIVES_INIT;
          score_d       = '0;
          level_d       = '0;
          won_d         = 1'b0;
          load_rows_d   = 1'b1;
          load_player_d = 1'b1;
          state_d       = PLAY;
        end
      end
      PLAY: begin
        // Tick counters only advance while staying in PLAY, so a wrap that
        // coincides with hit/goal produces no strobe in HIT/WIN, and every
        // PLAY entry starts them from zero.
        if (hit) begin
          lives_d = (lives_q == '0) ? '0 : lives_q - 2'd1;
          state_d = HIT;
        end else if (goal) begin
          score_d = (score_q == SCORE_TOP) ? score_q : score_q + 4'd1;
          level_d = (level_q == 2'd3) ? level_q : level_q + 2'd1;
          state_d = WIN;
        end else begin
          obst_cnt_d = obst_wrap ? '0 : obst_cnt_q + 1'b1;
          ply_cnt_d  = ply_wrap  ? '0 : ply_cnt_q + 1'b1;
          obst_en_d  = obst_wrap;
          if (ply_wrap && btn_one) begin
            move_en_d  = 1'b1;
            move_dir_d = btn_dir;
          end
        end
      end
      HIT: begin
        if (hold_q == HOLD_LIM) begin
          if (lives_q == '0) begin
            state_d = OVER;
          end else begin
            load_player_d = 1'b1;
            state_d       = PLAY;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      WIN: begin
        if (hold_q == HOLD_LIM) begin
          if (score_q == SCORE_TOP) begin
            won_d   = 1'b1;
            state_d = OVER;
          end else begin
            load_rows_d   = 1'b1;
            load_player_d = 1'b1;
            state_d       = PLAY;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      obst_cnt_q    <= '0;
      ply_cnt_q     <= '0;
      hold_q        <= '0;
      obst_en_q     <= 1'b0;
      move_en_q     <= 1'b0;
      move_dir_q    <= '0;
      load_rows_q   <= 1'b0;
      load_player_q <= 1'b0;
      lives_q       <= '0;
      score_q       <= '0;
      level_q       <= '0;
      won_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      obst_cnt_q    <= obst_cnt_d;
      ply_cnt_q     <= ply_cnt_d;
      hold_q        <= hold_d;
      obst_en_q     <= obst_en_d;
      move_en_q     <= move_en_d;
      move_dir_q    <= move_dir_d;
      load_rows_q   <= load_rows_d;
      load_player_q <= load_player_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      level_q       <= level_d;
      won_q         <= won_d;
    end
  end

  assign state       = state_q;
  assign obst_en     = obst_en_q;
  assign move_en     = move_en_q;
  assign move_dir    = move_dir_q;
  assign load_rows   = load_rows_q;
  assign load_player = load_player_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign level       = level_q;
  assign won         = won_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl with small divider/hold parameters.
module tb_game_seq_ctrl;

  logic       board_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic       hit = 1'b0, goal = 1'b0;
  logic [2:0] state;
  logic       obst_en, move_en, load_rows, load_player, won;
  logic [1:0] move_dir, lives, level;
  logic [3:0] score;

  int n_checks = 0;
  int n_errors = 0;
  int n_obst = 0, n_move = 0, n_lr = 0, n_lp = 0;
  int n;
  int snap_obst, snap_move, snap_lr, snap_lp;

  game_seq_ctrl #(
    .OBST_DIV  (16),
    .PLAYER_DIV(8),
    .HOLD_CYC  (4),
    .LIVES     (2),
    .SCORE_MAX (2)
  ) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .start      (start),
    .btn_u      (btn_u),
    .btn_d      (btn_d),
    .btn_l      (btn_l),
    .btn_r      (btn_r),
    .hit        (hit),
    .goal       (goal),
    .state      (state),
    .obst_en    (obst_en),
    .move_en    (move_en),
    .move_dir   (move_dir),
    .load_rows  (load_rows),
    .load_player(load_player),
    .lives      (lives),
    .score      (score),
    .level      (level),
    .won        (won)
  );

  always #5 board_clk = ~board_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge and tally strobes seen there.
  task automatic step(input int cycles);
    repeat (cycles) begin
      @(negedge board_clk);
      if (obst_en)     n_obst++;
      if (move_en)     n_move++;
      if (load_rows)   n_lr++;
      if (load_player) n_lp++;
    end
  endtask

  task automatic snap();
    snap_obst = n_obst; snap_move = n_move; snap_lr = n_lr; snap_lp = n_lp;
  endtask

  task automatic wait_obst(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!obst_en && cnt < 100);
  endtask

  task automatic wait_move(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!move_en && cnt < 100);
  endtask

  initial begin
    // 1. reset values, start, tick rates
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_lives", 32'(lives), 0);
    check("rst_pulses", 32'({obst_en, move_en, load_rows, load_player, won}), 0);
    step(2);
    reset = 1'b0;
    step(1);
    check("idle_hold", 32'(state), 0);
    start = 1'b1;
    step(1);
    check("start_state", 32'(state), 1);
    check("start_loads", 32'({load_rows, load_player}), 3);
    check("start_lives", 32'(lives), 2);
    snap();
    wait_obst(n);
    check("obst_first", 32'(n), 16);
    check("load_once", 32'(n_lr - snap_lr), 0);
    wait_obst(n);
    check("obst_period", 32'(n), 16);
    check("no_move_idle_btn", 32'(n_move - snap_move), 0);

    // 2. movement rules
    btn_r = 1'b1;
    wait_move(n);
    check("move_r_first", 32'(n), 8);
    check("move_r_dir", 32'(move_dir), 2);
    wait_move(n);
    check("move_r_period", 32'(n), 8);
    btn_l = 1'b1;
    snap();
    step(16);
    check("move_lr_none", 32'(n_move - snap_move), 0);
    btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b1;
    wait_move(n);
    check("move_u_first", 32'(n), 8);
    check("move_u_dir", 32'(move_dir), 1);
    btn_u = 1'b0;

    // 3. losing lives
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    check("hit1_state", 32'(state), 2);
    check("hit1_lives", 32'(lives), 1);
    snap();
    step(3);
    check("hit1_hold", 32'(state), 2);
    check("hit1_no_ticks", 32'((n_obst - snap_obst) + (n_move - snap_move)), 0);
    step(1);
    check("hit1_resume", 32'(state), 1);
    check("hit1_loads", 32'({load_rows, load_player}), 1);
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    check("hit2_lives", 32'(lives), 0);
    snap();
    step(4);
    check("hit2_over", 32'(state), 4);
    check("hit2_won", 32'(won), 0);
    check("hit2_no_load", 32'(n_lp - snap_lp), 0);

    // start still high from the previous game: must not restart
    step(3);
    check("over_held_start", 32'(state), 4);

    // 4. winning and speed-up
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    check("g2_state", 32'(state), 1);
    check("g2_lives", 32'(lives), 2);
    goal = 1'b1;
    step(1);
    goal = 1'b0;
    check("win1_state", 32'(state), 3);
    check("win1_score", 32'(score), 1);
    check("win1_level", 32'(level), 1);
    step(4);
    check("win1_resume", 32'(state), 1);
    check("win1_loads", 32'({load_rows, load_player}), 3);
    wait_obst(n);
    check("obst_lvl1", 32'(n), 8);
    goal = 1'b1;
    step(1);
    goal = 1'b0;
    check("win2_score", 32'(score), 2);
    check("win2_level", 32'(level), 2);
    step(4);
    check("win2_over", 32'(state), 4);
    check("win2_won", 32'(won), 1);

    // 5. restart and hit/goal priority
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    check("g3_state", 32'(state), 1);
    check("g3_clear", 32'({score, lives, level, won}), 32'({4'd0, 2'd2, 2'd0, 1'b0}));
    hit = 1'b1; goal = 1'b1;
    step(1);
    hit = 1'b0; goal = 1'b0;
    check("prio_state", 32'(state), 2);
    check("prio_score", 32'(score), 0);
    check("prio_lives", 32'(lives), 1);
    step(4);
    check("prio_resume", 32'(state), 1);

    // 6. reset in the middle of a WIN hold
    goal = 1'b1;
    step(1);
    goal = 1'b0;
    check("win3_state", 32'(state), 3);
    step(2);
    start = 1'b0;
    snap();
    reset = 1'b1;
    #1;
    check("mrst_state", 32'(state), 0);
    check("mrst_regs", 32'({lives, score, level}), 0);
    step(3);
    check("mrst_no_pulses",
          32'((n_obst - snap_obst) + (n_move - snap_move) + (n_lr - snap_lr) + (n_lp - snap_lp)), 0);
    reset = 1'b0;
    step(2);
    check("mrst_idle", 32'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
